// File: rtl/maze_generator_if.sv
// Maze generator bus: random-byte feed, start/busy handshake and the two
// wall vectors consumed by scene drawing and player movement.
interface maze_generator_if;
   logic [7:0]   rnd;
   logic         start;
   logic         busy;
   logic [159:0] h_walls;
   logic [164:0] v_walls;

   modport master (output rnd, output start, input busy, input h_walls, input v_walls);
   modport slave  (input rnd, input start, output busy, output h_walls, output v_walls);
endinterface

// File: rtl/maze_generator.sv
// Sidewinder maze generator for the fixed 10x15 playfield, one cell carved
// per clock. Walls start all-set on CLEAR and are knocked down during CARVE.
// Optional feature macro: MAZE_GEN_LOOPS_EN (extra north openings => loops).
module maze_generator (
   input  logic            clk,
   input  logic            rst,
   maze_generator_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1,
      S_CARVE = 2'd2
   } state_t;

   state_t       r_state;
   state_t       w_next_state;

   logic [3:0]   r_x;
   logic [3:0]   r_y;
   logic [3:0]   r_run_start;
   logic [159:0] r_h_walls;
   logic [164:0] r_v_walls;

   logic         w_busy;
   logic         w_clear;
   logic         w_carve;
   logic         w_last_cell;
   logic         w_close;
   logic         w_v_clr;
   logic [7:0]   w_v_idx;
   logic         w_h_clr;
   logic [7:0]   w_h_idx;
   logic         w_loop_clr;
   logic [7:0]   w_loop_idx;

   // Column inside the current run that gets the northward opening:
   // run_start + floor(frac * run_len / 128), always <= x.
   function automatic logic [3:0] pick_k(input logic [3:0] run_start,
                                         input logic [3:0] x,
                                         input logic [6:0] frac);
      logic [3:0]  run_len;
      logic [10:0] prod;
      run_len = x - run_start + 4'd1;
      prod    = {4'd0, frac} * {7'd0, run_len};
      return run_start + 4'(prod >> 7);
   endfunction

   // Bit index of the wall above cell (x,y).
   function automatic logic [7:0] h_index(input logic [3:0] y, input logic [3:0] x);
      return {4'd0, y} * 8'd10 + {4'd0, x};
   endfunction

   // Bit index of the wall left of column x in row y (x may be 10).
   function automatic logic [7:0] v_index(input logic [3:0] y, input logic [3:0] x);
      return {4'd0, y} * 8'd11 + {4'd0, x};
   endfunction

   assign w_last_cell = (r_x == 4'd9) && (r_y == 4'd14);

   // State register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // Next-state logic: start is only looked at while idle
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next_state = S_CLEAR;
         S_CLEAR: w_next_state = S_CARVE;
         S_CARVE: if (w_last_cell) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // State decode into busy and datapath strobes
   always_comb begin
      w_busy  = 1'b0;
      w_clear = 1'b0;
      w_carve = 1'b0;
      case (r_state)
         S_CLEAR: begin w_busy = 1'b1; w_clear = 1'b1; end
         S_CARVE: begin w_busy = 1'b1; w_carve = 1'b1; end
         default: ;
      endcase
   end

   // Carve decision for the current cell from the live random byte
   always_comb begin
      w_close    = 1'b0;
      w_v_clr    = 1'b0;
      w_v_idx    = '0;
      w_h_clr    = 1'b0;
      w_h_idx    = '0;
      w_loop_clr = 1'b0;
      w_loop_idx = '0;
      if (r_y == 4'd0) begin
         // Top row is one long corridor; the east border stays closed.
         w_v_clr = (r_x != 4'd9);
         w_v_idx = v_index(4'd0, r_x + 4'd1);
      end else begin
         w_close = (r_x == 4'd9) | bus.rnd[0];
         if (w_close) begin
            w_h_clr = 1'b1;
            w_h_idx = h_index(r_y, pick_k(r_run_start, r_x, bus.rnd[7:1]));
         end else begin
            w_v_clr = 1'b1;
            w_v_idx = v_index(r_y, r_x + 4'd1);
`ifdef MAZE_GEN_LOOPS_EN
            w_loop_clr = (r_y >= 4'd2) && (bus.rnd[7:4] == 4'hF);
            w_loop_idx = h_index(r_y, r_x);
`endif
         end
      end
   end

   // Wall storage and carve cursor
   always_ff @(posedge clk) begin
      if (rst) begin
         r_h_walls   <= '1;
         r_v_walls   <= '1;
         r_x         <= 4'd0;
         r_y         <= 4'd0;
         r_run_start <= 4'd0;
      end else if (w_clear) begin
         r_h_walls   <= '1;
         r_v_walls   <= '1;
         r_x         <= 4'd0;
         r_y         <= 4'd0;
         r_run_start <= 4'd0;
      end else if (w_carve) begin
         if (w_v_clr)    r_v_walls[w_v_idx]    <= 1'b0;
         if (w_h_clr)    r_h_walls[w_h_idx]    <= 1'b0;
         if (w_loop_clr) r_h_walls[w_loop_idx] <= 1'b0;
         if (w_close)    r_run_start <= (r_x == 4'd9) ? 4'd0 : r_x + 4'd1;
         if (r_x == 4'd9) begin
            r_x <= 4'd0;
            r_y <= w_last_cell ? 4'd0 : r_y + 4'd1;
         end else begin
            r_x <= r_x + 4'd1;
         end
      end
   end

   assign bus.busy    = w_busy;
   assign bus.h_walls = r_h_walls;
   assign bus.v_walls = r_v_walls;

endmodule

// File: tb/tb_maze_generator.sv
// Testbench for maze_generator: batch sidewinder reference model fed by the
// recorded random bytes, per-cycle compare process, and directed scenarios.
`timescale 1ns/1ps
module tb_maze_generator;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   maze_generator_if bus();
   maze_generator dut (.clk(clk), .rst(rst), .bus(bus));

   logic [7:0] tb_rnd;
   logic       tb_start;
   assign bus.rnd   = tb_rnd;
   assign bus.start = tb_start;

   int checks = 0;
   int errors = 0;

   // ---------------- random byte source ----------------
   bit         lfsr_mode = 1'b0;
   logic [7:0] lfsr;

   function automatic logic [7:0] lfsr_step(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

   always @(posedge clk) begin
      #1;
      if (lfsr_mode) begin
         lfsr   = lfsr_step(lfsr);
         tb_rnd = lfsr;
      end
   end

   // ---------------- reference model ----------------
   function automatic void build_maze(input logic [7:0] s[150],
                                      output logic [159:0] h,
                                      output logic [164:0] v);
      int rs, len, k;
      logic [7:0] b;
      h = '1;
      v = '1;
      for (int y = 0; y < 15; y++) begin
         rs = 0;
         for (int x = 0; x < 10; x++) begin
            b = s[y*10+x];
            if (y == 0) begin
               if (x < 9) v[x+1] = 1'b0;
            end else if (x == 9 || b[0]) begin
               len = x - rs + 1;
               k   = rs + (int'(b[7:1]) * len) / 128;
               h[y*10+k] = 1'b0;
               rs  = x + 1;
            end else begin
               v[y*11+x+1] = 1'b0;
`ifdef MAZE_GEN_LOOPS_EN
               if (y >= 2 && b[7:4] == 4'hF) h[y*10+x] = 1'b0;
`endif
            end
         end
      end
   endfunction

   logic [159:0] exp_h;
   logic [164:0] exp_v;
   bit           exp_busy;
   int           mcnt;
   logic [7:0]   samp[150];

   // Model timeline: idle, one clear cycle, then 150 cells each sampling rnd.
   always @(posedge clk) begin
      if (rst) begin
         mcnt = 0; exp_busy = 1'b0; exp_h = '1; exp_v = '1;
      end else if (mcnt == 0) begin
         if (tb_start) begin mcnt = 1; exp_busy = 1'b1; end
      end else if (mcnt == 1) begin
         mcnt = 2;
      end else begin
         samp[mcnt-2] = tb_rnd;
         if (mcnt == 151) begin
            build_maze(samp, exp_h, exp_v);
            mcnt = 0;
            exp_busy = 1'b0;
         end else begin
            mcnt++;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   bit chk_en = 1'b0;
   always @(negedge clk) begin
      if (chk_en) begin
         checks++;
         if (bus.busy !== exp_busy) begin
            errors++;
            $display("FAIL cyc_busy t=%0t got %b expected %b", $time, bus.busy, exp_busy);
         end
         if (!exp_busy) begin
            checks++;
            if (bus.h_walls !== exp_h || bus.v_walls !== exp_v) begin
               errors++;
               $display("FAIL cyc_walls t=%0t got h=%h v=%h expected h=%h v=%h",
                        $time, bus.h_walls, bus.v_walls, exp_h, exp_v);
            end
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, got, expv);
      end
   endtask

   task automatic chk_w(input string nm, input logic [164:0] got, input logic [164:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s got %h expected %h", nm, got, expv);
      end
   endtask

   function automatic int cleared(input logic [159:0] h, input logic [164:0] v);
      return 325 - $countones(h) - $countones(v);
   endfunction

   function automatic bit borders_ok(input logic [159:0] h, input logic [164:0] v);
      bit ok;
      ok = (h[9:0] == 10'h3FF) && (h[159:150] == 10'h3FF);
      for (int y = 0; y < 15; y++) ok = ok & v[y*11] & v[y*11+10];
      return ok;
   endfunction

   function automatic int reach_count(input logic [159:0] h, input logic [164:0] v);
      bit seen[150];
      int q[$];
      int c, x, y, n;
      foreach (seen[i]) seen[i] = 1'b0;
      q.push_back(0); seen[0] = 1'b1; n = 1;
      while (q.size() > 0) begin
         c = q.pop_front(); x = c % 10; y = c / 10;
         if (y > 0  && !h[y*10+x]     && !seen[c-10]) begin seen[c-10] = 1'b1; n++; q.push_back(c-10); end
         if (y < 14 && !h[(y+1)*10+x] && !seen[c+10]) begin seen[c+10] = 1'b1; n++; q.push_back(c+10); end
         if (x > 0  && !v[y*11+x]     && !seen[c-1])  begin seen[c-1]  = 1'b1; n++; q.push_back(c-1);  end
         if (x < 9  && !v[y*11+x+1]   && !seen[c+1])  begin seen[c+1]  = 1'b1; n++; q.push_back(c+1);  end
      end
      return n;
   endfunction

   // Launch a generation; dur = number of cycles busy was seen high.
   // pulse_at >= 0 re-asserts start during that CARVE cycle.
   task automatic run(input bit use_lfsr, input logic [7:0] val, input int pulse_at, output int dur);
      @(negedge clk);
      lfsr_mode = use_lfsr; lfsr = val; tb_rnd = val; tb_start = 1'b1;
      @(negedge clk);
      tb_start = 1'b0;
      dur = 0;
      while (bus.busy === 1'b1 && dur < 400) begin
         tb_start = (pulse_at >= 0 && dur == pulse_at + 1);
         dur++;
         @(negedge clk);
      end
      tb_start = 1'b0;
      if (dur >= 400) begin
         errors++;
         $display("FAIL run_timeout busy still high after %0d cycles", dur);
      end
   endtask

   // Hand-derived wall images for constant rnd
   localparam logic [159:0] H00 = {10'h3FF, {14{10'h3FE}}, 10'h3FF};
   localparam logic [164:0] V00 = {15{11'h401}};
   localparam logic [159:0] H01 = {10'h3FF, 140'd0, 10'h3FF};
   localparam logic [164:0] V01 = {{14{11'h7FF}}, 11'h401};

   logic [7:0]   s_const[150];
   logic [159:0] mh, sav_h;
   logic [164:0] mv, sav_v;
   int           dur;
   logic [7:0]   seed;

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; tb_start = 1'b0; tb_rnd = 8'h00;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_en = 1'b1;

      // Reset state
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_h_ones", $countones(bus.h_walls), 160);
      chk("rst_v_ones", $countones(bus.v_walls), 165);

      // Pin the model itself against hand-derived images
      foreach (s_const[i]) s_const[i] = 8'h00;
      build_maze(s_const, mh, mv);
      chk_w("model_h_00", {5'd0, mh}, {5'd0, H00});
      chk_w("model_v_00", mv, V00);
      foreach (s_const[i]) s_const[i] = 8'h01;
      build_maze(s_const, mh, mv);
      chk_w("model_h_01", {5'd0, mh}, {5'd0, H01});
      chk_w("model_v_01", mv, V01);

      // Constant 0x00
      run(1'b0, 8'h00, -1, dur);
      chk("c00_busy_len", dur, 151);
      chk_w("c00_h", {5'd0, bus.h_walls}, {5'd0, H00});
      chk_w("c00_v", bus.v_walls, V00);
      chk("c00_cleared", cleared(bus.h_walls, bus.v_walls), 149);

      // Constant 0x01
      run(1'b0, 8'h01, -1, dur);
      chk("c01_busy_len", dur, 151);
      chk_w("c01_h", {5'd0, bus.h_walls}, {5'd0, H01});
      chk_w("c01_v", bus.v_walls, V01);

      // LFSR-driven runs with random seeds
      for (int i = 0; i < 20; i++) begin
         seed = 8'($urandom_range(1, 255));
         run(1'b1, seed, -1, dur);
         chk("rnd_busy_len", dur, 151);
`ifdef MAZE_GEN_LOOPS_EN
         chk("rnd_cleared_min", 32'(cleared(bus.h_walls, bus.v_walls) >= 149), 1);
`else
         chk("rnd_cleared", cleared(bus.h_walls, bus.v_walls), 149);
`endif
         chk("rnd_borders", 32'(borders_ok(bus.h_walls, bus.v_walls)), 1);
         chk("rnd_reach", reach_count(bus.h_walls, bus.v_walls), 150);
      end

      // Reset during CARVE cell 70
      seed = 8'($urandom_range(1, 255));
      @(negedge clk);
      lfsr_mode = 1'b1; lfsr = seed; tb_rnd = seed; tb_start = 1'b1;
      @(negedge clk);
      tb_start = 1'b0;
      repeat (71) @(negedge clk);
      chk("pre_rst_busy", 32'(bus.busy), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", 32'(bus.busy), 0);
      chk("midrst_h_ones", $countones(bus.h_walls), 160);
      chk("midrst_v_ones", $countones(bus.v_walls), 165);
      run(1'b1, seed, -1, dur);
      chk("post_rst_busy_len", dur, 151);
      chk("post_rst_reach", reach_count(bus.h_walls, bus.v_walls), 150);

      // Start re-pulsed during CARVE cell 30 must be ignored
      seed = 8'($urandom_range(1, 255));
      run(1'b1, seed, -1, dur);
      sav_h = bus.h_walls; sav_v = bus.v_walls;
      run(1'b1, seed, 30, dur);
      chk("repulse_busy_len", dur, 151);
      chk_w("repulse_h_same", {5'd0, bus.h_walls}, {5'd0, sav_h});
      chk_w("repulse_v_same", bus.v_walls, sav_v);

      // Constant 0xF0: loop openings only when the feature is built in
      run(1'b0, 8'hF0, -1, dur);
      chk("cf0_busy_len", dur, 151);
      chk("cf0_borders", 32'(borders_ok(bus.h_walls, bus.v_walls)), 1);
`ifdef MAZE_GEN_LOOPS_EN
      chk("cf0_cleared", cleared(bus.h_walls, bus.v_walls), 266);
      chk("cf0_rows2_open", 32'(bus.h_walls[149:20] == 130'd0), 1);
`else
      chk("cf0_cleared", cleared(bus.h_walls, bus.v_walls), 149);
`endif

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/maze_generator.md
# maze_generator

Builds a random perfect maze for the 10×15 cell playfield, replacing the fixed wall patterns the top level currently feeds to the scene renderer and to player movement. It sits upstream of scene drawing: it consumes `random_byte` output and, while idle, drives the `h_walls` and `v_walls` vectors. It uses the sidewinder algorithm and carves one cell per clock. The top level keeps the TFT init, scene and player stages held off while `busy` is high.

## Interface

Parameters:
- None. The grid is fixed at 10 columns (x = 0..9) by 15 rows (y = 0..14).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `rnd`  in  8  random byte. One sample is consumed per CARVE cycle.
- `start`  in  1  single-cycle request to generate. Honoured only in IDLE.
- `busy`  out  1  high while generating.
- `h_walls`  out  160  horizontal walls.
  - Bit y*10+x is the wall above cell (x,y).
  - Rows y = 0..15; row 15 is the bottom border.
- `v_walls`  out  165  vertical walls.
  - Bit y*11+x is the wall left of cell (x,y).
  - Columns x = 0..10; column 10 is the right border.

## Operation

State machine: IDLE, CLEAR, CARVE.

- **IDLE**: `busy`=0 and walls hold their value. `start`=1 moves to CLEAR.
- **CLEAR** (1 cycle):
  - Set every bit of `h_walls` and `v_walls` to 1.
  - Set x=0, y=0, run_start=0.
  - Move to CARVE.
- **CARVE** (one cell (x,y) per cycle, row-major, x fastest):
  - **Row y=0**: if x<9, clear `v_walls[x+1]` (carve east). At x=9 do nothing.
  - **Rows y≥1, close condition**: close = (x==9) | `rnd[0]`.
  - **Close**:
    - run_len = x − run_start + 1, range 1..10, 4 bits.
    - k = run_start + ((`rnd[7:1]` × run_len) >> 7). The product is 11 bits and k ≤ x is guaranteed.
    - Clear `h_walls[y*10+k]`.
    - run_start ← x+1, or 0 when x==9.
  - **Otherwise**: clear `v_walls[y*11+x+1]`.
  - **Advance**: x==9 → x=0 and y+1. At (9,14), return to IDLE after that cell's carve.
- **Invariants**:
  - Outer borders are never cleared: h rows 0 and 15, v columns 0 and 10.
  - Exactly 149 wall bits are cleared per run (spanning tree of 150 cells), unless the loop feature is enabled.
- **Control rules**:
  - `start` during CLEAR or CARVE is ignored.
  - `rnd` is sampled combinationally on each CARVE cycle and is not registered.

## Timing

- Reset: `busy`=0, all `h_walls` and `v_walls` bits = 1, state IDLE, x=y=run_start=0.
- `start` sampled high at edge N:
  - `busy`=1 from N+1.
  - CLEAR occupies cycle N+1.
  - CARVE occupies cycles N+2..N+151.
  - `busy`=0 and the maze is final from N+152.
- Total `busy` duration: 151 cycles.
- Wall outputs change only while `busy`=1; consumers read them only when `busy`=0.
- Reset mid-CLEAR or mid-CARVE:
  - Takes effect on the next edge.
  - Walls return to all ones and `busy`=0.
  - No partial maze remains.
- `rst` and `start` in the same cycle: reset wins.

## Configuration

`MAZE_GEN_LOOPS_EN`:
- **Defined**: in rows y≥2, a cell that carves east with `rnd[7:4]`==4'hF also clears its north wall `h_walls[y*10+x]`. This adds loops, so more than 149 bits may be cleared. Timing is unchanged.
- **Undefined**: the maze is strictly perfect, with exactly 149 bits cleared.

## Test plan

1. **Constant `rnd`=8'h00** (macro off), start → `busy` high exactly 151 cycles.
   - All interior v walls (x=1..9) are 0 in all rows.
   - `h_walls[y*10]`=0 for y=1..14; every other h bit is 1.
2. **Constant `rnd`=8'h01**:
   - h rows 1..14 are all 0.
   - Interior v walls are 1 in rows 1..14 and 0 in row 0.
   - Borders are all 1.
3. **LFSR `rnd`, 20 seeds**:
   - Exactly 149 cleared bits each run.
   - Borders intact.
   - BFS from (0,0) reaches all 150 cells.
4. **Reset pulse at CARVE cycle 70** → next cycle `busy`=0 and all walls are 1. A fresh start then completes in 151 cycles.
5. **`start` pulsed again at CARVE cycle 30** → ignored. `busy` falls at N+152, with the same result as an unpulsed run given identical `rnd`.
6. **`MAZE_GEN_LOOPS_EN` defined, `rnd`=8'hF0**:
   - Rows y≥2 carve east with the north wall also cleared for x=0..8.
   - Cleared count > 149; borders intact.
